// File: rtl/aes_uart_pkg.sv
// Shared types and constants for the AES UART host: FSM state encodings,
// frame geometry and the oversample divider helper.
package aes_uart_pkg;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RX, FINISH} host_state_e;
    typedef enum logic [1:0] {R_HUNT, R_START, R_DATA, R_STOP} rx_state_e;

    localparam int OS_RATE    = 16;  // ticks per bit
    localparam int NBYTES     = 16;  // bytes per block
    localparam int FRAME_BITS = 10;  // start + 8 data + stop
    localparam int MID_SAMPLE = 8;   // tick index of the mid-bit sample

    // Clocks per oversample tick, truncated, never below 1.
    function automatic int calc_os_div(input int clk_freq, input int baud);
        int d;
        d = clk_freq / (baud * OS_RATE);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/aes_uart_host_if.sv
// Host-side block interface: request (Start/TxData) and result/status signals.
interface aes_uart_host_if;
    import aes_uart_pkg::*;

    logic                  Start;
    logic [NBYTES*8-1:0]   TxData;
    logic [NBYTES*8-1:0]   RxData;
    logic                  Busy;
    logic                  Done;
    logic                  FrameErr;
    logic                  Timeout;

    modport master (output Start, TxData, input RxData, Busy, Done, FrameErr, Timeout);
    modport slave  (input Start, TxData, output RxData, Busy, Done, FrameErr, Timeout);
endinterface

// File: rtl/uart_byte_rx.sv
// Oversampled 8N1 byte receiver: 2-flop synchroniser, falling-edge arm,
// mid-start validation, LSB-first shift and stop check. Emits a one-cycle
// byte_valid with stop_err; forced back to hunting while en_i is low.
module uart_byte_rx
    import aes_uart_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic       en_i,
    input  logic       tick_i,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       stop_err_o,
    output logic       hunting_o
);
    rx_state_e   state_q, state_d;
    logic [2:0]  sync_q;      // [0],[1] synchroniser, [2] previous for edge detect
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        rx_s, fall;

    assign rx_s = sync_q[1];
    assign fall = sync_q[2] & ~sync_q[1];

    // Synchroniser and receiver state registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync_q  <= 3'b111;
            state_q <= R_HUNT;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], rx_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Next-state: arm on falling edge, validate mid-start, then sample every 16 ticks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        err_d   = err_q;
        if (!en_i) begin
            state_d = R_HUNT;
        end else begin
            case (state_q)
                R_HUNT: if (fall) begin
                    state_d = R_START;
                    cnt_d   = '0;
                end
                R_START: if (tick_i) begin
                    if (cnt_q == 4'(MID_SAMPLE)) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        // A high line mid-start means the edge was a glitch.
                        state_d = rx_s ? R_HUNT : R_DATA;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                R_DATA: if (tick_i) begin
                    if (cnt_q == 4'(OS_RATE - 1)) begin
                        cnt_d   = '0;
                        shift_d = {rx_s, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = R_STOP;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                R_STOP: if (tick_i) begin
                    if (cnt_q == 4'(OS_RATE - 1)) begin
                        valid_d = 1'b1;
                        err_d   = ~rx_s;
                        state_d = R_HUNT;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: state_d = R_HUNT;
            endcase
        end
    end

    assign byte_valid_o = valid_q;
    assign byte_o       = shift_q;
    assign stop_err_o   = err_q;
    assign hunting_o    = (state_q == R_HUNT);

endmodule

// File: rtl/aes_uart_host.sv
// AES UART host: sends a 128-bit block as 16 8N1 bytes (plus GAP_BITS idle
// bits each), then collects 16 returned bytes into RxData.
// Optional feature macro: RX_TIMEOUT_EN (abort receive after TIMEOUT_BITS
// idle bit-times; Timeout is tied low when undefined).
module aes_uart_host
    import aes_uart_pkg::*;
#(
    parameter int CLK_FREQ     = 100000000,
    parameter int BAUD         = 9600,
    parameter int GAP_BITS     = 2,
    parameter int TIMEOUT_BITS = 200
) (
    input  logic            Clk,
    input  logic            Rst,
    aes_uart_host_if.slave  host,
    output logic            Tx,
    input  logic            Rx
);
    localparam int W       = NBYTES * 8;
    localparam int OS_DIV  = calc_os_div(CLK_FREQ, BAUD);
    localparam int DIV_W   = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam int TX_BITS = FRAME_BITS + GAP_BITS;
    localparam int BIT_W   = $clog2(TX_BITS + 1);

    host_state_e       state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [3:0]        tcnt_q, tcnt_d;
    logic [BIT_W-1:0]  tbit_q, tbit_d;
    logic [3:0]        tbyte_q, tbyte_d;
    logic [W-1:0]      txsh_q, txsh_d;
    logic              tx_q, tx_d;
    logic [3:0]        rcnt_q, rcnt_d;
    logic [W-1:0]      shadow_q, shadow_d;
    logic [W-1:0]      rxdata_q, rxdata_d;
    logic              ferr_q, ferr_d;
    logic              tick;
    logic              rx_valid, rx_err, rx_hunting;
    logic [7:0]        rx_byte;
`ifdef RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_BITS + 1);
    logic [3:0]        to_tick_q, to_tick_d;
    logic [TO_W-1:0]   to_bits_q, to_bits_d;
    logic              tmo_q, tmo_d;
`else
    logic              unused_hunting;
    assign unused_hunting = rx_hunting;
`endif

    assign tick = (div_q == DIV_W'(OS_DIV - 1));

    uart_byte_rx u_rx (
        .Clk          (Clk),
        .Rst          (Rst),
        .en_i         (state_q == WAIT_RX),
        .tick_i       (tick),
        .rx_i         (Rx),
        .byte_valid_o (rx_valid),
        .byte_o       (rx_byte),
        .stop_err_o   (rx_err),
        .hunting_o    (rx_hunting)
    );

    // State and datapath registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            tcnt_q   <= '0;
            tbit_q   <= '0;
            tbyte_q  <= '0;
            txsh_q   <= '0;
            tx_q     <= 1'b1;
            rcnt_q   <= '0;
            shadow_q <= '0;
            rxdata_q <= '0;
            ferr_q   <= 1'b0;
`ifdef RX_TIMEOUT_EN
            to_tick_q <= '0;
            to_bits_q <= '0;
            tmo_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            tcnt_q   <= tcnt_d;
            tbit_q   <= tbit_d;
            tbyte_q  <= tbyte_d;
            txsh_q   <= txsh_d;
            tx_q     <= tx_d;
            rcnt_q   <= rcnt_d;
            shadow_q <= shadow_d;
            rxdata_q <= rxdata_d;
            ferr_q   <= ferr_d;
`ifdef RX_TIMEOUT_EN
            to_tick_q <= to_tick_d;
            to_bits_q <= to_bits_d;
            tmo_q     <= tmo_d;
`endif
        end
    end

    // Transaction FSM: transmit shifter, receive collection, completion.
    always_comb begin
        state_d  = state_q;
        div_d    = tick ? '0 : div_q + 1'b1;
        tcnt_d   = tcnt_q;
        tbit_d   = tbit_q;
        tbyte_d  = tbyte_q;
        txsh_d   = txsh_q;
        tx_d     = tx_q;
        rcnt_d   = rcnt_q;
        shadow_d = shadow_q;
        rxdata_d = rxdata_q;
        ferr_d   = ferr_q;
`ifdef RX_TIMEOUT_EN
        to_tick_d = to_tick_q;
        to_bits_d = to_bits_q;
        tmo_d     = tmo_q;
`endif
        case (state_q)
            IDLE: if (host.Start) begin
                state_d  = SEND;
                div_d    = '0;
                tcnt_d   = '0;
                tbit_d   = '0;
                tbyte_d  = '0;
                txsh_d   = host.TxData;
                tx_d     = 1'b0;        // start bit of byte 0 goes out immediately
                shadow_d = '0;
                ferr_d   = 1'b0;
`ifdef RX_TIMEOUT_EN
                tmo_d    = 1'b0;
`endif
            end
            SEND: if (tick) begin
                if (tcnt_q == 4'(OS_RATE - 1)) begin
                    tcnt_d = '0;
                    if (tbit_q == BIT_W'(TX_BITS - 1)) begin
                        tbit_d = '0;
                        if (tbyte_q == 4'(NBYTES - 1)) begin
                            state_d = WAIT_RX;
                            tx_d    = 1'b1;
                            rcnt_d  = '0;
`ifdef RX_TIMEOUT_EN
                            to_tick_d = '0;
                            to_bits_d = '0;
`endif
                        end else begin
                            tbyte_d = tbyte_q + 4'd1;
                            tx_d    = 1'b0;
                        end
                    end else begin
                        tbit_d = tbit_q + 1'b1;
                        // Entering data bits 1..8: shift the block out LSB first,
                        // which leaves the next byte aligned at [7:0].
                        if (tbit_q < BIT_W'(8)) begin
                            tx_d   = txsh_q[0];
                            txsh_d = txsh_q >> 1;
                        end else begin
                            tx_d = 1'b1;
                        end
                    end
                end else begin
                    tcnt_d = tcnt_q + 4'd1;
                end
            end
            WAIT_RX: begin
                if (rx_valid) begin
                    shadow_d = {rx_byte, shadow_q[W-1:8]};
                    rcnt_d   = rcnt_q + 4'd1;
                    if (rx_err) ferr_d = 1'b1;
                    if (rcnt_q == 4'(NBYTES - 1)) begin
                        rxdata_d = {rx_byte, shadow_q[W-1:8]};
                        state_d  = FINISH;
                    end
                end
`ifdef RX_TIMEOUT_EN
                if (rx_valid) begin
                    to_tick_d = '0;
                    to_bits_d = '0;
                end else if (to_bits_q == TO_W'(TIMEOUT_BITS)) begin
                    // Abort only between bytes; a byte in flight may still land.
                    if (rx_hunting) begin
                        state_d = FINISH;
                        tmo_d   = 1'b1;
                    end
                end else if (tick) begin
                    to_tick_d = to_tick_q + 4'd1;
                    if (to_tick_q == 4'(OS_RATE - 1)) to_bits_d = to_bits_q + 1'b1;
                end
`endif
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign Tx            = tx_q;
    assign host.RxData   = rxdata_q;
    assign host.Busy     = (state_q == SEND) || (state_q == WAIT_RX);
    assign host.Done     = (state_q == FINISH);
    assign host.FrameErr = ferr_q;
`ifdef RX_TIMEOUT_EN
    assign host.Timeout  = tmo_q;
`else
    assign host.Timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_aes_uart_host.sv
// Bench for aes_uart_host: decodes Tx, echoes the bytes back on Rx and
// scores transmitted bytes and returned blocks against queued expectations.
module tb_aes_uart_host;
    localparam int CLK_FREQ     = 1600;
    localparam int BAUD         = 100;
    localparam int GAP_BITS     = 2;
    localparam int TIMEOUT_BITS = 200;
    localparam int BIT_CLKS     = 16;
    localparam int BYTE_CLKS    = (10 + GAP_BITS) * BIT_CLKS;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    logic Tx;
    logic Rx  = 1'b1;

    aes_uart_host_if hif ();

    aes_uart_host #(
        .CLK_FREQ     (CLK_FREQ),
        .BAUD         (BAUD),
        .GAP_BITS     (GAP_BITS),
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .host (hif),
        .Tx   (Tx),
        .Rx   (Rx)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int last_low_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_send_cyc = 0;
    logic [127:0] rx_at_done;
    logic         busy_at_done;

    logic [7:0]   exp_q[$];
    logic [127:0] exp_rx_q[$];
    logic [7:0]   echo_q[$];

    always @(posedge Clk) cyc++;

    always @(negedge Clk) begin
        if (Tx === 1'b0) last_low_cyc = cyc;
        if (hif.Done === 1'b1) begin
            done_cnt++;
            done_cyc     = cyc;
            rx_at_done   = hif.RxData;
            busy_at_done = hif.Busy;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic start_block(input logic [127:0] data);
        @(negedge Clk);
        hif.TxData = data;
        hif.Start  = 1'b1;
        @(negedge Clk);
        hif.Start  = 1'b0;
        start_cyc  = cyc - 1;
        checks++;
        if (Tx !== 1'b0) begin
            errors++;
            $display("FAIL start_tx: Tx=%b expected 0 at cycle 1", Tx);
        end
        checks++;
        if (hif.Busy !== 1'b1) begin
            errors++;
            $display("FAIL start_busy: Busy=%b expected 1", hif.Busy);
        end
    endtask

    task automatic decode_byte(output logic [7:0] b, output bit ok);
        int n;
        ok = 1'b1;
        n  = 0;
        b  = '0;
        while (Tx !== 1'b0 && n < 400) begin
            @(negedge Clk);
            n++;
        end
        if (Tx !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        repeat (BIT_CLKS / 2) @(negedge Clk);
        for (int i = 0; i < 8; i++) begin
            repeat (BIT_CLKS) @(negedge Clk);
            b[i] = Tx;
        end
        repeat (BIT_CLKS) @(negedge Clk);
        if (Tx !== 1'b1) ok = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        Rx = 1'b0;
        repeat (BIT_CLKS) @(negedge Clk);
        for (int i = 0; i < 8; i++) begin
            Rx = b[i];
            repeat (BIT_CLKS) @(negedge Clk);
        end
        Rx = stop;
        repeat (BIT_CLKS) @(negedge Clk);
        Rx = 1'b1;
        repeat (BIT_CLKS) @(negedge Clk);
    endtask

    // One full transaction: send block, decode/score Tx, echo nback bytes,
    // wait for Done and score the result.
    task automatic run_block(input logic [127:0] data, input int bad_idx,
                             input bit glitch, input int nback);
        logic [7:0]   b;
        logic [7:0]   exp_b;
        logic [127:0] exp_rx;
        bit           ok;
        int           d0;
        int           n;
        for (int k = 0; k < 16; k++) exp_q.push_back(data[8*k +: 8]);
        if (nback == 16) exp_rx_q.push_back(data);
        d0 = done_cnt;
        start_block(data);
        for (int k = 0; k < 16; k++) begin
            decode_byte(b, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL tx_frame: byte %0d not framed correctly on Tx", k);
                exp_q.delete();
                exp_rx_q.delete();
                echo_q.delete();
                return;
            end
            exp_b = exp_q.pop_front();
            checks++;
            if (b !== exp_b) begin
                errors++;
                $display("FAIL tx_byte: byte %0d got %02h expected %02h", k, b, exp_b);
            end
            echo_q.push_back(b);
        end
        repeat (64) @(negedge Clk);
        checks++;
        if (Tx !== 1'b1 || hif.Busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_rx_idle: Tx=%b Busy=%b expected 1 1", Tx, hif.Busy);
        end
        if (glitch) begin
            Rx = 1'b0;
            repeat (4) @(negedge Clk);
            Rx = 1'b1;
            repeat (40) @(negedge Clk);
        end
        for (int k = 0; k < nback; k++) begin
            b = echo_q.pop_front();
            send_byte(b, (k == bad_idx) ? 1'b0 : 1'b1);
            if (bad_idx >= 0 && k == bad_idx - 1) begin
                checks++;
                if (hif.FrameErr !== 1'b0) begin
                    errors++;
                    $display("FAIL ferr_before: FrameErr=%b expected 0 after byte %0d", hif.FrameErr, k);
                end
            end
            if (k == bad_idx) begin
                checks++;
                if (hif.FrameErr !== 1'b1) begin
                    errors++;
                    $display("FAIL ferr_after: FrameErr=%b expected 1 after byte %0d", hif.FrameErr, k);
                end
            end
        end
        echo_q.delete();
        last_send_cyc = cyc;
        n = 0;
        while (done_cnt == d0 && n < TIMEOUT_BITS * BIT_CLKS + 1000) begin
            @(negedge Clk);
            n++;
        end
        repeat (4) @(negedge Clk);
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL done_pulse: saw %0d Done cycles expected 1", done_cnt - d0);
        end
        checks++;
        if (busy_at_done !== 1'b0 || hif.Busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_end: Busy at Done=%b after=%b expected 0 0", busy_at_done, hif.Busy);
        end
        checks++;
        if (hif.FrameErr !== (bad_idx >= 0)) begin
            errors++;
            $display("FAIL ferr_end: FrameErr=%b expected %b", hif.FrameErr, bad_idx >= 0);
        end
        checks++;
        if (hif.Timeout !== (nback < 16)) begin
            errors++;
            $display("FAIL timeout_flag: Timeout=%b expected %b", hif.Timeout, nback < 16);
        end
        if (nback == 16 && exp_rx_q.size() > 0) begin
            exp_rx = exp_rx_q.pop_front();
            checks++;
            if (rx_at_done !== exp_rx || hif.RxData !== exp_rx) begin
                errors++;
                $display("FAIL rx_data: got %032h expected %032h", hif.RxData, exp_rx);
            end
        end
    endtask

    task automatic test_reset();
        hif.Start  = 1'b0;
        hif.TxData = '0;
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        checks++;
        if (Tx !== 1'b1) begin errors++; $display("FAIL reset_tx: Tx=%b expected 1", Tx); end
        checks++;
        if (hif.RxData !== 128'h0) begin errors++; $display("FAIL reset_rxdata: RxData=%032h expected 0", hif.RxData); end
        checks++;
        if (hif.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: Busy=%b expected 0", hif.Busy); end
        checks++;
        if (hif.Done !== 1'b0) begin errors++; $display("FAIL reset_done: Done=%b expected 0", hif.Done); end
        checks++;
        if (hif.FrameErr !== 1'b0) begin errors++; $display("FAIL reset_ferr: FrameErr=%b expected 0", hif.FrameErr); end
        checks++;
        if (hif.Timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: Timeout=%b expected 0", hif.Timeout); end
    endtask

    task automatic test_loopback();
        int exp_last;
        run_block(128'h00112233445566778899AABBCCDDEEFF, -1, 1'b0, 16);
        // Byte 15 is 0x00: its last low cycle is the end of data bit 7.
        exp_last = 1 + 15 * BYTE_CLKS + 9 * BIT_CLKS - 1;
        checks++;
        if (last_low_cyc - start_cyc != exp_last) begin
            errors++;
            $display("FAIL tx_last_low: last low cycle %0d expected %0d", last_low_cyc - start_cyc, exp_last);
        end
    endtask

    task automatic test_frame_err();
        logic [127:0] d;
        d = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
        run_block(d, 5, 1'b0, 16);
        checks++;
        if (hif.RxData[47:40] !== d[47:40]) begin
            errors++;
            $display("FAIL ferr_byte: RxData[47:40]=%02h expected %02h", hif.RxData[47:40], d[47:40]);
        end
    endtask

    task automatic test_glitch();
        run_block(128'hDEADBEEF0123456789ABCDEFFEDCBA98, -1, 1'b1, 16);
    endtask

    task automatic test_reset_mid();
        start_block(128'h5555AAAA5555AAAA00FF00FF00FF00FF);
        repeat (7 * BYTE_CLKS + 40) @(negedge Clk);
        checks++;
        if (Tx !== 1'b0) begin
            errors++;
            $display("FAIL mid_tx_pre: Tx=%b expected 0 in byte 7 data bit 1", Tx);
        end
        Rst = 1'b1;
        @(negedge Clk);
        checks++;
        if (Tx !== 1'b1 || hif.Busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: Tx=%b Busy=%b expected 1 0", Tx, hif.Busy);
        end
        checks++;
        if (hif.RxData !== 128'h0) begin
            errors++;
            $display("FAIL mid_reset_rxdata: RxData=%032h expected 0", hif.RxData);
        end
        Rst = 1'b0;
        repeat (2) @(negedge Clk);
        run_block(128'hA5A5A5A53C3C3C3C0F0F0F0F12345678, -1, 1'b0, 16);
    endtask

`ifdef RX_TIMEOUT_EN
    task automatic test_timeout();
        logic [127:0] prev;
        int           gap;
        prev = hif.RxData;
        run_block(128'h11111111222222223333333344444444, -1, 1'b0, 3);
        checks++;
        if (hif.RxData !== prev) begin
            errors++;
            $display("FAIL timeout_rxdata: RxData=%032h expected %032h", hif.RxData, prev);
        end
        gap = done_cyc - last_send_cyc;
        checks++;
        if (gap < TIMEOUT_BITS * BIT_CLKS - 64 || gap > TIMEOUT_BITS * BIT_CLKS + 64) begin
            errors++;
            $display("FAIL timeout_delay: Done %0d cycles after last byte expected about %0d", gap, TIMEOUT_BITS * BIT_CLKS);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_loopback();
        test_frame_err();
        test_glitch();
        test_reset_mid();
`ifdef RX_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
